// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register write-back countdowns that flag
// decode source operands whose pending write is not yet visible.
module reg_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int RNUM_WIDTH = 5,
  parameter int LATENCY    = 3,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RNUM_WIDTH-1:0] rnum1,
  input  logic [RNUM_WIDTH-1:0] rnum2,
  input  logic                  uses_rnum2,
  input  logic                  issue,
  input  logic                  is_write_reg,
  input  logic [RNUM_WIDTH-1:0] wnum,
  input  logic                  flush,
  output logic                  is_full_rnum1,
  output logic                  is_full_rnum2,
  output logic [RNUM_WIDTH:0]   busy_count,
  output logic                  any_pending
);

  localparam logic [CNT_WIDTH-1:0] LAT_C = CNT_WIDTH'(LATENCY);

  // Register 0 is hard-wired zero, so it has no counter at all.
  logic [CNT_WIDTH-1:0] cnt_r     [1:NUM_REGS-1];
  logic [CNT_WIDTH-1:0] cnt_nxt_s [1:NUM_REGS-1];
  logic [RNUM_WIDTH:0]  busy_nxt_s;
  logic [CNT_WIDTH-1:0] rd1_s;
  logic [CNT_WIDTH-1:0] rd2_s;
  logic                 wr_en_s;

  assign wr_en_s = issue & is_write_reg & (wnum != {RNUM_WIDTH{1'b0}});

  // Next counter state: flush beats reload, reload beats decrement.
  always_comb begin
    busy_nxt_s = {(RNUM_WIDTH + 1){1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        cnt_nxt_s[r] = {CNT_WIDTH{1'b0}};
      end else if (wr_en_s && (wnum == RNUM_WIDTH'(r))) begin
        cnt_nxt_s[r] = LAT_C;
      end else if (cnt_r[r] != {CNT_WIDTH{1'b0}}) begin
        cnt_nxt_s[r] = cnt_r[r] - {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
      end else begin
        cnt_nxt_s[r] = {CNT_WIDTH{1'b0}};
      end
      busy_nxt_s = busy_nxt_s +
                   {{RNUM_WIDTH{1'b0}}, (cnt_nxt_s[r] != {CNT_WIDTH{1'b0}})};
    end
  end

  // Source-operand lookup against pre-update state; r0 never matches.
  always_comb begin
    rd1_s = {CNT_WIDTH{1'b0}};
    rd2_s = {CNT_WIDTH{1'b0}};
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rnum1 == RNUM_WIDTH'(r)) begin
        rd1_s = cnt_r[r];
      end else begin
        rd1_s = rd1_s;
      end
      if (rnum2 == RNUM_WIDTH'(r)) begin
        rd2_s = cnt_r[r];
      end else begin
        rd2_s = rd2_s;
      end
    end
  end

  assign is_full_rnum1 = (rd1_s != {CNT_WIDTH{1'b0}});
  assign is_full_rnum2 = uses_rnum2 & (rd2_s != {CNT_WIDTH{1'b0}});

  // Counter state and the registered occupancy summary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_r[r] <= {CNT_WIDTH{1'b0}};
      end
      busy_count  <= {(RNUM_WIDTH + 1){1'b0}};
      any_pending <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      busy_count  <= busy_nxt_s;
      any_pending <= (busy_nxt_s != {(RNUM_WIDTH + 1){1'b0}});
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios followed
// by random traffic, compared against a per-register countdown model.
module tb_reg_scoreboard;

  localparam int NR  = 32;
  localparam int RW  = 5;
  localparam int LAT = 3;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rnum1, rnum2, wnum;
  logic          uses_rnum2, issue, is_write_reg, flush;
  logic          is_full_rnum1, is_full_rnum2, any_pending;
  logic [RW:0]   busy_count;

  int vectors     = 0;
  int miscompares = 0;
  int cnt_m[NR];

  reg_scoreboard #(.NUM_REGS(NR), .RNUM_WIDTH(RW), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rnum1(rnum1), .rnum2(rnum2), .uses_rnum2(uses_rnum2),
    .issue(issue), .is_write_reg(is_write_reg), .wnum(wnum), .flush(flush),
    .is_full_rnum1(is_full_rnum1), .is_full_rnum2(is_full_rnum2),
    .busy_count(busy_count), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  function automatic int busy_m();
    int n = 0;
    for (int r = 0; r < NR; r++) if (cnt_m[r] != 0) n++;
    return n;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NR; r++) cnt_m[r] = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one decode cycle, check hazards on pre-edge state, then the summary.
  task automatic apply(input logic [RW-1:0] r1, input logic [RW-1:0] r2, input logic u2,
                       input logic iss, input logic wr, input logic [RW-1:0] w,
                       input logic fl);
    rnum1 = r1; rnum2 = r2; uses_rnum2 = u2;
    issue = iss; is_write_reg = wr; wnum = w; flush = fl;
    #1;
    check("is_full_rnum1", {31'd0, is_full_rnum1}, (r1 != 0 && cnt_m[r1] != 0) ? 1 : 0);
    check("is_full_rnum2", {31'd0, is_full_rnum2}, (u2 && r2 != 0 && cnt_m[r2] != 0) ? 1 : 0);
    @(posedge clk);
    if (fl) begin
      clear_model();
    end else begin
      for (int r = 0; r < NR; r++) if (cnt_m[r] > 0) cnt_m[r]--;
      if (iss && wr && w != 0) cnt_m[w] = LAT;
    end
    #1;
    check("busy_count", {26'd0, busy_count}, busy_m());
    check("any_pending", {31'd0, any_pending}, (busy_m() != 0) ? 1 : 0);
  endtask

  initial begin
    clear_model();
    rst = 1'b0;
    rnum1 = 5'd5; rnum2 = 5'd6; uses_rnum2 = 1'b1;
    issue = 1'b0; is_write_reg = 1'b0; wnum = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {26'd0, busy_count}, 0);
    check("reset_any", {31'd0, any_pending}, 0);
    check("reset_full1", {31'd0, is_full_rnum1}, 0);
    check("reset_full2", {31'd0, is_full_rnum2}, 0);
    rst = 1'b1;
    apply(5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    // RAW hazard on r3, then free after LATENCY cycles
    apply(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0);
    repeat (4) apply(5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Writes to r0 never create a hazard
    apply(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    apply(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    // Reload of r7 two cycles after the first issue
    apply(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    apply(5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    apply(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
    repeat (4) apply(5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    // Flush with a simultaneous issue of r10
    apply(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    apply(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    apply(5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    apply(5'd9, 5'd4, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1);
    apply(5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    apply(5'd2, 5'd10, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    // rnum2 gating, then an async reset pulse between edges
    apply(5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0);
    apply(5'd1, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    apply(5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_full2", {31'd0, is_full_rnum2}, 0);
    check("async_rst_busy", {26'd0, busy_count}, 0);
    check("async_rst_any", {31'd0, any_pending}, 0);
    clear_model();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      apply(RW'($urandom_range(0, NR - 1)), RW'($urandom_range(0, NR - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), RW'($urandom_range(0, NR - 1)),
            1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
